// File: rtl/alu_acc_sequencer_if.sv
// Command, adder and result bundle between the accumulator sequencer and its environment.
// Latency: none, wiring only.
// Backpressure: cmd_valid/cmd_ready on the command side, res_valid/res_ready on the result side.
interface alu_acc_sequencer_if #(
  parameter int WIDTH = 8
);
  // command handshake
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  // combinational adder drive and return
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic             add_sub;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;
  // result handshake and status
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic             flag_z;
  logic             flag_c;
  logic             flag_n;
  logic             flag_v;
  logic [WIDTH-1:0] acc;

  // environment side: issues commands, supplies the adder, consumes results
  modport master (
    output cmd_valid, cmd_op, cmd_data, add_sum, add_cout, res_ready,
    input  cmd_ready, add_a, add_b, add_sub, res_valid, res_data,
           flag_z, flag_c, flag_n, flag_v, acc
  );

  // sequencer side
  modport slave (
    input  cmd_valid, cmd_op, cmd_data, add_sum, add_cout, res_ready,
    output cmd_ready, add_a, add_b, add_sub, res_valid, res_data,
           flag_z, flag_c, flag_n, flag_v, acc
  );
endinterface

// File: rtl/alu_acc_sequencer.sv
// Accumulator front end for an external combinational add/subtract stage with Z/C/N/V flags.
// Latency: command accepted at edge T, result captured at T+1, IDLE again after handshake (3 cycles min).
// Backpressure: one command in flight; cmd_ready low until the result is taken; RESP held while res_ready low.
module alu_acc_sequencer #(
  parameter int WIDTH = 8
) (
  input logic              clk,
  input logic              rst,
  alu_acc_sequencer_if.slave bus
);

  localparam logic [2:0] OP_CLR  = 3'd0;
  localparam logic [2:0] OP_LOAD = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_SUB  = 3'd3;
  localparam logic [2:0] OP_CMP  = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t     state;
  logic [2:0] op;

  logic sum_zero;
  logic load_zero;
  logic v_add;
  logic v_sub;

  // Flag terms from the registered operands and the adder's settled sum.
  // A LOAD value is parked on add_b, so its zero test comes from there.
  always_comb begin
    sum_zero  = (bus.add_sum == '0);
    load_zero = (bus.add_b == '0);
    v_add     = (bus.add_a[WIDTH-1] == bus.add_b[WIDTH-1]) &&
                (bus.add_sum[WIDTH-1] != bus.add_a[WIDTH-1]);
    v_sub     = (bus.add_a[WIDTH-1] != bus.add_b[WIDTH-1]) &&
                (bus.add_sum[WIDTH-1] != bus.add_a[WIDTH-1]);
  end

  // Control FSM with all outputs registered; reset aborts any command in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      op            <= OP_CLR;
      bus.cmd_ready <= 1'b1;
      bus.res_valid <= 1'b0;
      bus.res_data  <= '0;
      bus.acc       <= '0;
      bus.flag_z    <= 1'b0;
      bus.flag_c    <= 1'b0;
      bus.flag_n    <= 1'b0;
      bus.flag_v    <= 1'b0;
      bus.add_a     <= '0;
      bus.add_b     <= '0;
      bus.add_sub   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid && bus.cmd_ready) begin
            op            <= bus.cmd_op;
            bus.add_a     <= bus.acc;
            bus.add_b     <= bus.cmd_data;
            bus.add_sub   <= (bus.cmd_op == OP_SUB) || (bus.cmd_op == OP_CMP);
            bus.cmd_ready <= 1'b0;
            state         <= EXEC;
          end
        end
        EXEC: begin
          bus.res_valid <= 1'b1;
          state         <= RESP;
          case (op)
            OP_CLR: begin
              bus.acc      <= '0;
              bus.res_data <= '0;
              bus.flag_z   <= 1'b1;
              bus.flag_n   <= 1'b0;
            end
            OP_LOAD: begin
              bus.acc      <= bus.add_b;
              bus.res_data <= bus.add_b;
              bus.flag_z   <= load_zero;
              bus.flag_n   <= bus.add_b[WIDTH-1];
            end
            OP_ADD: begin
              bus.acc      <= bus.add_sum;
              bus.res_data <= bus.add_sum;
              bus.flag_z   <= sum_zero;
              bus.flag_c   <= bus.add_cout;
              bus.flag_n   <= bus.add_sum[WIDTH-1];
              bus.flag_v   <= v_add;
            end
            OP_SUB: begin
              bus.acc      <= bus.add_sum;
              bus.res_data <= bus.add_sum;
              bus.flag_z   <= sum_zero;
              bus.flag_c   <= bus.add_cout;
              bus.flag_n   <= bus.add_sum[WIDTH-1];
              bus.flag_v   <= v_sub;
            end
            OP_CMP: begin
              bus.res_data <= bus.add_sum;
              bus.flag_z   <= sum_zero;
              bus.flag_c   <= bus.add_cout;
              bus.flag_n   <= bus.add_sum[WIDTH-1];
              bus.flag_v   <= v_sub;
            end
            default: begin
              bus.res_data <= bus.acc;
            end
          endcase
        end
        RESP: begin
          if (bus.res_valid && bus.res_ready) begin
            bus.res_valid <= 1'b0;
            bus.cmd_ready <= 1'b1;
            state         <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_acc_sequencer.sv
// Directed bench for alu_acc_sequencer with a behavioural adder on the return path.
// Latency: checks result one cycle after the accepting edge (second edge counting acceptance).
// Backpressure: exercises res_ready held low, res_ready high on entry, and cmd_valid outside IDLE.
module tb_alu_acc_sequencer;

  localparam logic [2:0] OP_CLR  = 3'd0;
  localparam logic [2:0] OP_LOAD = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_SUB  = 3'd3;
  localparam logic [2:0] OP_CMP  = 3'd4;
  localparam logic [2:0] OP_NOP  = 3'd6;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  alu_acc_sequencer_if #(.WIDTH(8)) bus ();

  alu_acc_sequencer #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference adder: A + B, or A + ~B + 1 for subtract (carry = no borrow).
  logic [8:0] add_full;
  always_comb begin
    add_full     = {1'b0, bus.add_a} + {1'b0, (bus.add_sub ? ~bus.add_b : bus.add_b)} + {8'd0, bus.add_sub};
    bus.add_sum  = add_full[7:0];
    bus.add_cout = add_full[8];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] flags();
    return {bus.flag_z, bus.flag_c, bus.flag_n, bus.flag_v};
  endfunction

  // Present a command, wait for acceptance, then wait for res_valid.
  task automatic issue(input logic [2:0] op, input logic [7:0] data);
    int n;
    int lat;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = data;
    n = 0;
    while (!bus.cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("cmd_ready_wait", bus.cmd_ready, 1);
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    while (!bus.res_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check("res_latency", lat, 2);
  endtask

  task automatic complete();
    bus.res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.res_ready = 1'b0;
    check("res_valid_drop", bus.res_valid, 0);
    check("cmd_ready_back", bus.cmd_ready, 1);
  endtask

  // Flags packed as {Z, C, N, V}.
  task automatic expect_out(input string tag, input logic [7:0] res, input logic [7:0] accv,
                            input logic [3:0] f);
    check({tag, "_res"}, bus.res_data, res);
    check({tag, "_acc"}, bus.acc, accv);
    check({tag, "_flags"}, flags(), f);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'd0;
    bus.cmd_data  = 8'd0;
    bus.res_ready = 1'b0;
    repeat (2) @(negedge clk);

    check("rst_cmd_ready", bus.cmd_ready, 1);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_res_data", bus.res_data, 0);
    check("rst_acc", bus.acc, 0);
    check("rst_flags", flags(), 0);
    check("rst_add_a", bus.add_a, 0);
    check("rst_add_b", bus.add_b, 0);
    check("rst_add_sub", bus.add_sub, 0);
    rst = 1'b0;

    // 5 - 3 = 2, no borrow so C=1
    issue(OP_LOAD, 8'h05); expect_out("load05", 8'h05, 8'h05, 4'b0000); complete();
    issue(OP_SUB, 8'h03);
    check("sub_add_a", bus.add_a, 8'h05);
    check("sub_add_b", bus.add_b, 8'h03);
    check("sub_add_sub", bus.add_sub, 1);
    expect_out("sub", 8'h02, 8'h02, 4'b0100); complete();

    // signed overflow on add; LOAD keeps C from the SUB
    issue(OP_LOAD, 8'h7F); expect_out("load7f", 8'h7F, 8'h7F, 4'b0100); complete();
    issue(OP_ADD, 8'h01); expect_out("add_ovf", 8'h80, 8'h80, 4'b0011); complete();

    // unsigned wrap to zero, then compare zero against zero
    issue(OP_LOAD, 8'hFF); expect_out("loadff", 8'hFF, 8'hFF, 4'b0011); complete();
    issue(OP_ADD, 8'h01); expect_out("add_wrap", 8'h00, 8'h00, 4'b1100); complete();
    issue(OP_CMP, 8'h00); expect_out("cmp_zero", 8'h00, 8'h00, 4'b1100); complete();

    // signed overflow on subtract, compare leaves acc alone
    issue(OP_LOAD, 8'h80); expect_out("load80", 8'h80, 8'h80, 4'b0110); complete();
    issue(OP_SUB, 8'h01); expect_out("sub_ovf", 8'h7F, 8'h7F, 4'b0101); complete();
    issue(OP_CMP, 8'h10); expect_out("cmp10", 8'h6F, 8'h7F, 4'b0100); complete();

    // CLR keeps C/V; NOP reports acc without touching anything
    issue(OP_CLR, 8'hAA); expect_out("clr", 8'h00, 8'h00, 4'b1100); complete();
    issue(OP_LOAD, 8'h3C); expect_out("load3c", 8'h3C, 8'h3C, 4'b0100); complete();
    issue(OP_NOP, 8'h55);
    check("nop_add_sub", bus.add_sub, 0);
    expect_out("nop", 8'h3C, 8'h3C, 4'b0100); complete();

    // res_ready already high when RESP is entered: one-cycle result
    bus.res_ready = 1'b1;
    issue(OP_ADD, 8'h01); expect_out("add_fast", 8'h3D, 8'h3D, 4'b0000);
    @(posedge clk);
    @(negedge clk);
    bus.res_ready = 1'b0;
    check("fast_res_valid", bus.res_valid, 0);
    check("fast_cmd_ready", bus.cmd_ready, 1);

    // result held with res_ready low while a new command waits
    issue(OP_LOAD, 8'hA5);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_ADD;
    bus.cmd_data  = 8'h01;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_cmd_ready", bus.cmd_ready, 0);
      check("hold_res_valid", bus.res_valid, 1);
      check("hold_res_data", bus.res_data, 8'hA5);
      check("hold_flags", flags(), 4'b0010);
      check("hold_acc", bus.acc, 8'hA5);
    end
    bus.res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.res_ready = 1'b0;
    check("held_cmd_ready", bus.cmd_ready, 1);
    check("held_not_consumed", bus.acc, 8'hA5);
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check("held_add_a", bus.add_a, 8'hA5);
    check("held_add_b", bus.add_b, 8'h01);
    @(negedge clk);
    check("held_res_valid", bus.res_valid, 1);
    expect_out("held_add", 8'hA6, 8'hA6, 4'b0010);
    complete();

    // reset during EXEC of an ADD
    issue(OP_LOAD, 8'h10); complete();
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_ADD;
    bus.cmd_data  = 8'h20;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check("exec_add_a", bus.add_a, 8'h10);
    check("exec_add_b", bus.add_b, 8'h20);
    rst = 1'b1;
    #1;
    check("abort_acc", bus.acc, 0);
    check("abort_res_valid", bus.res_valid, 0);
    check("abort_res_data", bus.res_data, 0);
    check("abort_cmd_ready", bus.cmd_ready, 1);
    check("abort_flags", flags(), 0);
    check("abort_add_a", bus.add_a, 0);
    check("abort_add_b", bus.add_b, 0);
    check("abort_add_sub", bus.add_sub, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort_no_result", bus.res_valid, 0);
    check("abort_acc_after", bus.acc, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
